movegen_position_tx: RTL and testbench

- Transmitter end of the position stream consumed by the move generator's lookup stage.
- Holds a 64-square board image, written by the host/search controller.
- On a start request, snapshots the board and emits it as a 64-beat nibble stream with a start-of-packet marker on beat 0, under valid/ready flow control.
- Sits between the search controller and one or more movegen receivers.

---
 rtl/chess_pkg.sv | 38 +++
 rtl/movegen_position_tx.sv | 91 +++++++++
 tb/tb_movegen_position_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared piece encoding and board geometry for the position stream transmitter and its receivers.
package chess_pkg;

  localparam int NUM_SQUARES = 64;
  localparam int PIECE_W     = 4;

  typedef logic [PIECE_W-1:0] piece_t;
  typedef logic [5:0]         rankfile_t;

  localparam piece_t EMPTY  = 4'h0;
  localparam piece_t PAWN   = 4'h1;
  localparam piece_t KNIGHT = 4'h2;
  localparam piece_t BISHOP = 4'h3;
  localparam piece_t ROOK   = 4'h4;
  localparam piece_t QUEEN  = 4'h5;
  localparam piece_t KING   = 4'h6;
  localparam piece_t BLACK  = 4'h8;

  // Square index is rank*8+file; ranks 0/1 are white, ranks 6/7 black.
  function automatic piece_t initial_square(input rankfile_t sq);
    piece_t back;
    case (sq[2:0])
      3'd0, 3'd7: back = ROOK;
      3'd1, 3'd6: back = KNIGHT;
      3'd2, 3'd5: back = BISHOP;
      3'd3:       back = QUEEN;
      default:    back = KING;
    endcase
    case (sq[5:3])
      3'd0:    return back;
      3'd1:    return PAWN;
      3'd6:    return BLACK | PAWN;
      3'd7:    return BLACK | back;
      default: return EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/movegen_position_tx.sv
// Board image plus snapshot, streamed as 64 nibble beats (sop on square 0, eop on square 63)
// under valid/ready flow control.
module movegen_position_tx
  import chess_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [5:0]         wr_rankfile,
  input  logic [PIECE_W-1:0] wr_piece,
  input  logic               clear,
  input  logic               load_initial,
  input  logic               start,
  output logic               busy,
  output logic               out_pos_valid,
  output logic [PIECE_W-1:0] out_pos_data,
  output logic               out_pos_sop,
  output logic               out_pos_eop,
  input  logic               out_pos_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t    state;
  rankfile_t cnt;
  piece_t    board      [NUM_SQUARES];
  piece_t    board_nxt  [NUM_SQUARES];
  piece_t    snapshot   [NUM_SQUARES];

  logic accept;
  logic take_snapshot;

  // The snapshot is taken from board_nxt so same-cycle host updates are included.
  always_comb begin
    board_nxt = board;
    if (clear) begin
      for (int i = 0; i < NUM_SQUARES; i++) board_nxt[i] = EMPTY;
    end else if (load_initial) begin
      for (int i = 0; i < NUM_SQUARES; i++) board_nxt[i] = initial_square(rankfile_t'(i));
    end else if (wr_en) begin
      board_nxt[wr_rankfile] = wr_piece;
    end
  end

  assign accept        = out_pos_valid && out_pos_ready;
  assign take_snapshot = start && ((state == IDLE) || (accept && cnt == 6'd63));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      out_pos_valid <= 1'b0;
      out_pos_data  <= '0;
      out_pos_sop   <= 1'b0;
      out_pos_eop   <= 1'b0;
      for (int i = 0; i < NUM_SQUARES; i++) begin
        board[i]    <= EMPTY;
        snapshot[i] <= EMPTY;
      end
    end else begin
      board <= board_nxt;
      if (take_snapshot) begin
        snapshot      <= board_nxt;
        state         <= SEND;
        cnt           <= '0;
        busy          <= 1'b1;
        out_pos_valid <= 1'b1;
        out_pos_data  <= board_nxt[0];
        out_pos_sop   <= 1'b1;
        out_pos_eop   <= 1'b0;
      end else if (state == SEND && accept) begin
        if (cnt == 6'd63) begin
          state         <= IDLE;
          cnt           <= '0;
          busy          <= 1'b0;
          out_pos_valid <= 1'b0;
          out_pos_data  <= '0;
          out_pos_sop   <= 1'b0;
          out_pos_eop   <= 1'b0;
        end else begin
          cnt          <= cnt + 6'd1;
          out_pos_data <= snapshot[cnt + 6'd1];
          out_pos_sop  <= 1'b0;
          out_pos_eop  <= (cnt == 6'd62);
        end
      end
    end
  end

endmodule

// File: tb/tb_movegen_position_tx.sv
// Directed bench for movegen_position_tx: frame content, backpressure, back-to-back, precedence, async reset.
module tb_movegen_position_tx;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_rankfile;
  logic [3:0] wr_piece;
  logic       clear;
  logic       load_initial;
  logic       start;
  logic       busy;
  logic       out_pos_valid;
  logic [3:0] out_pos_data;
  logic       out_pos_sop;
  logic       out_pos_eop;
  logic       out_pos_ready;

  int checks = 0;
  int errors = 0;

  logic [3:0] init_img  [64];
  logic [3:0] mod_img   [64];
  logic [3:0] zero_img  [64];
  logic [3:0] back_rank [8];
  int         cycles;

  movegen_position_tx dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_rankfile   (wr_rankfile),
    .wr_piece      (wr_piece),
    .clear         (clear),
    .load_initial  (load_initial),
    .start         (start),
    .busy          (busy),
    .out_pos_valid (out_pos_valid),
    .out_pos_data  (out_pos_data),
    .out_pos_sop   (out_pos_sop),
    .out_pos_eop   (out_pos_eop),
    .out_pos_ready (out_pos_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  // Consumes one frame; inputs change 1ns after posedge, outputs sampled on negedge.
  task automatic receiveFrame(input logic [3:0] exp [64], input bit toggle_ready,
                              input int wr_beat, input bit start_on_eop, output int cyc);
    int idx;
    idx = 0;
    cyc = 0;
    while (idx < 64 && cyc < 400) begin
      out_pos_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      wr_en         = (idx == wr_beat);
      wr_rankfile   = 6'd63;
      wr_piece      = 4'h5;
      start         = start_on_eop && (idx == 63);
      @(negedge clk);
      checkOutput("valid", {31'd0, out_pos_valid}, 32'd1);
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput($sformatf("data[%0d]", idx), {28'd0, out_pos_data}, {28'd0, exp[idx]});
      checkOutput($sformatf("sop[%0d]", idx), {31'd0, out_pos_sop}, {31'd0, idx == 0});
      checkOutput($sformatf("eop[%0d]", idx), {31'd0, out_pos_eop}, {31'd0, idx == 63});
      if (out_pos_ready) idx++;
      cyc++;
      applyStimulus;
    end
    wr_en         = 1'b0;
    start         = 1'b0;
    out_pos_ready = 1'b1;
    checkOutput("frame_complete", idx, 32'd64);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'd0, out_pos_valid}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    applyStimulus;
  endtask

  initial begin
    back_rank = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    for (int i = 0; i < 64; i++) begin
      zero_img[i] = 4'h0;
      init_img[i] = 4'h0;
    end
    for (int f = 0; f < 8; f++) begin
      init_img[f]      = back_rank[f];
      init_img[8 + f]  = 4'h1;
      init_img[48 + f] = 4'h9;
      init_img[56 + f] = back_rank[f] | 4'h8;
    end
    mod_img     = init_img;
    mod_img[63] = 4'h5;

    rst = 1'b1; wr_en = 1'b0; wr_rankfile = '0; wr_piece = '0;
    clear = 1'b0; load_initial = 1'b0; start = 1'b0; out_pos_ready = 1'b1;

    #2;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_pos_valid}, 32'd0);
    checkOutput("rst_sop", {31'd0, out_pos_sop}, 32'd0);
    checkOutput("rst_eop", {31'd0, out_pos_eop}, 32'd0);
    checkOutput("rst_data", {28'd0, out_pos_data}, 32'd0);
    applyStimulus;
    rst = 1'b0;

    // Initial position, ready held high
    applyStimulus;
    load_initial = 1'b1;
    applyStimulus;
    load_initial = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("pre_start_valid", {31'd0, out_pos_valid}, 32'd0);
    applyStimulus;
    start = 1'b0;
    receiveFrame(init_img, 1'b0, -1, 1'b0, cycles);
    checkOutput("frame1_cycles", cycles, 32'd64);
    checkIdle("after_frame1");

    // Mid-frame write to square 63 only affects the next frame
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(init_img, 1'b0, 10, 1'b0, cycles);
    checkIdle("after_frame2");
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(mod_img, 1'b0, -1, 1'b0, cycles);
    checkIdle("after_frame3");

    // Backpressure: ready toggles every other cycle
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(mod_img, 1'b1, -1, 1'b0, cycles);
    checkOutput("bp_cycles", cycles, 32'd127);
    checkIdle("after_bp");

    // Back-to-back: start on accepted eop, second frame follows with no gap
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(mod_img, 1'b0, -1, 1'b1, cycles);
    receiveFrame(mod_img, 1'b0, -1, 1'b0, cycles);
    checkOutput("b2b_cycles", cycles, 32'd64);
    checkIdle("after_b2b");

    // Precedence: clear wins over load_initial and wr_en
    clear = 1'b1; load_initial = 1'b1; wr_en = 1'b1; wr_rankfile = 6'd5; wr_piece = 4'h7;
    applyStimulus;
    clear = 1'b0; load_initial = 1'b0; wr_en = 1'b0;
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(zero_img, 1'b0, -1, 1'b0, cycles);
    checkIdle("after_prec");

    // Async reset mid-frame
    load_initial = 1'b1;
    applyStimulus;
    load_initial = 1'b0;
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    repeat (30) applyStimulus;
    @(negedge clk);
    checkOutput("beat30_valid", {31'd0, out_pos_valid}, 32'd1);
    applyStimulus;
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'd0, out_pos_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_eop", {31'd0, out_pos_eop}, 32'd0);
    applyStimulus;
    rst = 1'b0;
    applyStimulus;
    start = 1'b1;
    applyStimulus;
    start = 1'b0;
    receiveFrame(zero_img, 1'b0, -1, 1'b0, cycles);
    checkIdle("after_rst_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
